// File: rtl/rs_gf_pkg.sv
// Shared GF(2^5) definitions for the RS decoder datapath.
// Field polynomial x^5+x^2+1; GF_POLY is the reduction term of x^5.
package rs_gf_pkg;
  localparam int GF_W = 5;
  localparam logic [GF_W-1:0] GF_POLY = 5'b00101;

  // Minimum tag width able to name n requesters.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gfmul_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module gfmul_rr_pick #(
  parameter int NREQ = 4,
  parameter int TAGW = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [TAGW-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [TAGW-1:0] o_idx
);
  logic w_found;

  // Two passes: indices >= ptr first, then the wrapped-around ones below ptr.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (i_en && !w_found && i_req[j] && (j >= int'(i_ptr))) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = TAGW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (i_en && !w_found && i_req[j] && (j < int'(i_ptr))) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = TAGW'(j);
      end
    end
  end
endmodule

// File: rtl/lcpmult.sv
// Combinational GF(2^5) polynomial-basis multiplier (MSB-first Horner form).
module lcpmult
  import rs_gf_pkg::*;
(
  input  logic [GF_W-1:0] i_a,
  input  logic [GF_W-1:0] i_b,
  output logic [GF_W-1:0] o_p
);
  always_comb begin
    o_p = '0;
    for (int i = GF_W - 1; i >= 0; i--) begin
      o_p = {o_p[GF_W-2:0], 1'b0} ^ (o_p[GF_W-1] ? GF_POLY : '0);
      if (i_b[i]) o_p = o_p ^ i_a;
    end
  end
endmodule

// File: rtl/gfmul_arbiter.sv
// Round-robin arbiter sharing one GF(2^5) multiplier among NREQ requesters.
// Optional per-requester XOR accumulators: define GFMUL_ARB_ACCUM_EN.
module gfmul_arbiter
  import rs_gf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 3
) (
  input  logic                 i_clock,
  input  logic                 i_resetn,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_acc,
  input  logic [GF_W*NREQ-1:0] i_opa,
  input  logic [GF_W*NREQ-1:0] i_opb,
  input  logic                 i_out_hold,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_out_valid,
  output logic [GF_W-1:0]      o_out_data,
  output logic [TAGW-1:0]      o_out_tag
);
  if (TAGW < tag_w(NREQ)) begin : g_bad_tagw
    $error("gfmul_arbiter: TAGW too small for NREQ");
  end

  logic [TAGW-1:0] r_ptr;
  logic [NREQ-1:0] w_gnt;
  logic [TAGW-1:0] w_idx;
  logic [GF_W-1:0] w_a, w_b, w_prod, w_res;
  logic            w_en;

  assign w_en  = i_resetn & ~i_out_hold;
  assign o_gnt = w_gnt;

  gfmul_rr_pick #(.NREQ(NREQ), .TAGW(TAGW)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a = i_opa[i*GF_W +: GF_W];
        w_b = i_opb[i*GF_W +: GF_W];
      end
    end
  end

  lcpmult u_mul (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

`ifdef GFMUL_ARB_ACCUM_EN
  logic [NREQ-1:0][GF_W-1:0] r_acc;
  logic [GF_W-1:0]           w_acc_cur;
  logic                      w_acc_sel;

  always_comb begin
    w_acc_cur = '0;
    w_acc_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_acc_cur = r_acc[i];
        w_acc_sel = i_acc[i];
      end
    end
  end

  assign w_res = w_acc_sel ? (w_acc_cur ^ w_prod) : w_prod;

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_acc <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (w_gnt[i]) r_acc[i] <= w_res;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^i_acc;
  assign w_res    = w_prod;
`endif

  // Hold freezes everything, including the pointer; idle cycles flush the result.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_tag   <= '0;
      r_ptr       <= '0;
    end else if (!i_out_hold) begin
      if (|w_gnt) begin
        o_out_valid <= 1'b1;
        o_out_data  <= w_res;
        o_out_tag   <= w_idx;
        r_ptr       <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
      end else begin
        o_out_valid <= 1'b0;
        o_out_data  <= '0;
        o_out_tag   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gfmul_arbiter.sv
// Scoreboard bench for gfmul_arbiter (NREQ=4); accumulate checks follow GFMUL_ARB_ACCUM_EN.
module tb_gfmul_arbiter;
  localparam int NREQ = 4;
  localparam int TAGW = 3;

  logic             gclk = 1'b0;
  logic             resetn;
  logic [NREQ-1:0]  req, acc, gnt;
  logic [5*NREQ-1:0] opa, opb;
  logic             out_hold, out_valid;
  logic [4:0]       out_data;
  logic [TAGW-1:0]  out_tag;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int         mdl_ptr = 0;
  logic       mdl_v = 0;
  logic [4:0] mdl_d = 0;
  logic [2:0] mdl_t = 0;
  logic [4:0] mdl_acc [NREQ];
  logic [8:0] sb [$];
  int         last_gi;
  logic [3:0] last_gnt;

  always #5 gclk = ~gclk;

  gfmul_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .i_clock    (gclk),
    .i_resetn   (resetn),
    .i_req      (req),
    .i_acc      (acc),
    .i_opa      (opa),
    .i_opb      (opb),
    .i_out_hold (out_hold),
    .o_gnt      (gnt),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .o_out_tag  (out_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Schoolbook product then reduce high terms with x^5 = x^2 + 1.
  function automatic logic [4:0] gf_ref(input logic [4:0] a, input logic [4:0] b);
    logic [8:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (9'(a) << i);
    for (int k = 8; k >= 5; k--) if (p[k]) p = p ^ (9'b000100101 << (k - 5));
    return p[4:0];
  endfunction

  // One clock: check gnt mid-cycle, push expected result, compare after the edge.
  task automatic cyc();
    logic [3:0] eg;
    logic [4:0] a, b, p, nd;
    logic [8:0] e;
    int gi;
    @(negedge gclk);
    eg = '0;
    gi = -1;
    if (resetn && !out_hold)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mdl_ptr + k) % NREQ;
        if (gi < 0 && req[j]) gi = j;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    last_gi  = gi;
    last_gnt = gnt;
    if (!resetn) begin
      mdl_v = 0; mdl_d = 0; mdl_t = 0; mdl_ptr = 0;
      for (int i = 0; i < NREQ; i++) mdl_acc[i] = '0;
    end else if (out_hold) begin
      // everything holds
    end else if (gi >= 0) begin
      a = opa[gi*5 +: 5];
      b = opb[gi*5 +: 5];
      p = gf_ref(a, b);
`ifdef GFMUL_ARB_ACCUM_EN
      nd = acc[gi] ? (mdl_acc[gi] ^ p) : p;
      mdl_acc[gi] = nd;
`else
      nd = p;
`endif
      mdl_v = 1; mdl_d = nd; mdl_t = 3'(gi); mdl_ptr = (gi + 1) % NREQ;
    end else begin
      mdl_v = 0; mdl_d = 0; mdl_t = 0;
    end
    sb.push_back({mdl_v, mdl_d, mdl_t});
    @(posedge gclk);
    #1;
    e = sb.pop_front();
    chk("valid", 32'(out_valid), 32'(e[8]));
    chk("data",  32'(out_data),  32'(e[7:3]));
    chk("tag",   32'(out_tag),   32'(e[2:0]));
  endtask

  initial begin
    logic [4:0] sv_d;
    logic [2:0] sv_t;
    for (int i = 0; i < NREQ; i++) mdl_acc[i] = '0;
    resetn = 0; req = '1; acc = '0; out_hold = 0;
    opa = 20'($urandom); opb = 20'($urandom);

    // reset with all requests high
    cyc(); chk("rst_gnt", 32'(last_gnt), 0);
    out_hold = 1;
    cyc(); chk("rst_gnt_hold", 32'(last_gnt), 0);
    chk("rst_v", 32'(out_valid), 0); chk("rst_d", 32'(out_data), 0); chk("rst_t", 32'(out_tag), 0);
    out_hold = 0; resetn = 1;
    cyc(); chk("first_gnt", 32'(last_gi), 0);
    req = '0;
    cyc();

    // single multiply: x^4 * x = x^2 + 1
    req = 4'b0100; opa[14:10] = 5'b10000; opb[14:10] = 5'b00010;
    cyc();
    chk("single_gnt", 32'(last_gnt), 32'h4);
    chk("single_v", 32'(out_valid), 1); chk("single_d", 32'(out_data), 32'h05); chk("single_t", 32'(out_tag), 2);

    // bring ptr back to 0 via requester 3, then fairness
    req = 4'b1000; cyc(); chk("wrap_gnt", 32'(last_gi), 3);
    req = '1;
    for (int k = 0; k < 8; k++) begin
      opa = 20'($urandom); opb = 20'($urandom);
      cyc(); chk("fair_order", 32'(last_gi), 32'(k % 4));
    end

    // hold with valid data present and req[1] waiting
    req = 4'b0010; cyc(); chk("pre_hold_gnt", 32'(last_gi), 1);
    req = 4'b0010; opa[9:5] = 5'b10110; opb[9:5] = 5'b01011;
    sv_d = out_data; sv_t = out_tag;
    out_hold = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_gnt", 32'(last_gnt), 0);
      chk("hold_v", 32'(out_valid), 1); chk("hold_d", 32'(out_data), 32'(sv_d)); chk("hold_t", 32'(out_tag), 32'(sv_t));
    end
    out_hold = 0;
    cyc(); chk("post_hold_gnt", 32'(last_gnt), 32'h2);
    chk("post_hold_d", 32'(out_data), 32'(gf_ref(5'b10110, 5'b01011)));

    // idle flushes outputs; ptr (now 2) kept, so {0,1,3} grants 3 next
    req = '0; cyc();
    chk("idle_v", 32'(out_valid), 0); chk("idle_d", 32'(out_data), 0);
    req = 4'b1011; cyc(); chk("idle_ptr", 32'(last_gi), 3);
    req = '0; cyc();

    // accumulate sequence on requester 0
    req = 4'b0001; acc = 4'b0000; opa[4:0] = 5'b00011; opb[4:0] = 5'b00001;
    cyc(); chk("acc_first", 32'(out_data), 32'h03);
    acc = 4'b0001; opa[4:0] = 5'b00110;
    cyc();
`ifdef GFMUL_ARB_ACCUM_EN
    chk("acc_second", 32'(out_data), 32'h05);
`else
    chk("acc_ignored", 32'(out_data), 32'h06);
`endif

    // random traffic including hold and occasional reset
    for (int k = 0; k < 60; k++) begin
      req = 4'($urandom); acc = 4'($urandom);
      opa = 20'($urandom); opb = 20'($urandom);
      out_hold = ($urandom_range(0, 3) == 0);
      resetn   = ($urandom_range(0, 19) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
